// File: rtl/odu_test_gen_pkg.sv
// Shared constants and FSM encoding for the ODU test-pattern source.
package odu_test_pkg;
  localparam int DATA_W         = 384;
  localparam int BYTES_PER_WORD = 48;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;
endpackage

// File: rtl/odu_test_gen_if.sv
// Channel bus carrying framed pattern words from the generator to its consumers.
interface odu_test_gen_if;
  import odu_test_pkg::*;

  logic [DATA_W-1:0] data_chid;
  logic              valid_chid;
  logic              fs_chid;
  logic              rs_chid;
  logic [7:0]        mfas_chid;

  modport master (output data_chid, valid_chid, fs_chid, rs_chid, mfas_chid);
  modport slave  (input  data_chid, valid_chid, fs_chid, rs_chid, mfas_chid);
endinterface

// File: rtl/odu_test_word_build.sv
// Combinational word assembler: overhead fill on row-start words, incrementing
// payload bytes elsewhere, optional bit-0 flip of the first payload byte.
module odu_test_word_build
  import odu_test_pkg::*;
#(
  parameter int          OH_BYTES   = 2,
  parameter logic [15:0] OH_PATTERN = 16'hF628
) (
  input  logic [7:0]        seq_i,
  input  logic              rs_i,
  input  logic              inj_i,
  output logic [DATA_W-1:0] word_o,
  output logic [7:0]        seq_next_o
);
  logic [7:0] byte_v;
  int         first_pay;

  // Byte k sits at the top of the word first; payload counts from first_pay.
  always_comb begin
    word_o    = '0;
    byte_v    = '0;
    first_pay = rs_i ? OH_BYTES : 0;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (k < first_pay) begin
        byte_v = ((k % 2) == 0) ? OH_PATTERN[15:8] : OH_PATTERN[7:0];
      end else begin
        byte_v = seq_i + 8'(k - first_pay);
        if (inj_i && (k == first_pay)) byte_v[0] = ~byte_v[0];
      end
      word_o[DATA_W-1-8*k -: 8] = byte_v;
    end
    seq_next_o = seq_i + 8'(BYTES_PER_WORD - first_pay);
  end
endmodule

// File: rtl/odu_test_gen.sv
// ODU test-pattern source: framed incrementing-byte words with idle gaps,
// per-frame MFAS and one-shot data / MFAS error injection.
module odu_test_gen
  import odu_test_pkg::*;
#(
  parameter int          WORDS_PER_ROW = 80,
  parameter int          ROWS          = 4,
  parameter int          OH_BYTES      = 2,
  parameter logic [15:0] OH_PATTERN    = 16'hF628
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_enable,
  input  logic [7:0]           i_gap_len,
  input  logic                 i_inj_data,
  input  logic                 i_inj_mfas,
  odu_test_gen_if.master       ch,
  output logic                 o_busy,
  output logic [15:0]          o_frame_count
);
  localparam int WW = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [WW-1:0] LAST_WORD = WW'(WORDS_PER_ROW - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);

  state_e            st_q, st_d;
  logic [WW-1:0]     word_cnt_q, word_cnt_d;
  logic [RW-1:0]     row_cnt_q, row_cnt_d;
  logic [7:0]        gap_cnt_q, gap_cnt_d;
  logic [7:0]        seq_q, seq_d;
  logic [7:0]        mfas_q, mfas_d;
  logic              seen_fs_q, seen_fs_d;
  logic              inj_data_q, inj_data_d;
  logic              inj_mfas_q, inj_mfas_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              fs_q, fs_d;
  logic              rs_q, rs_d;
  logic [7:0]        mfas_out_q, mfas_out_d;
  logic              busy_q, busy_d;
  logic [15:0]       frame_count_q, frame_count_d;

  logic              emit, is_rs, is_fs, last_word;
  logic              inj_data_eff, inj_mfas_eff;
  logic [DATA_W-1:0] bld_word;
  logic [7:0]        bld_seq;

  // A pulse on the cycle before an emission edge targets the word emitted at that edge.
  assign inj_data_eff = inj_data_q | i_inj_data;
  assign inj_mfas_eff = inj_mfas_q | i_inj_mfas;
  assign is_rs        = (word_cnt_q == '0);
  assign is_fs        = is_rs && (row_cnt_q == '0);
  assign last_word    = (word_cnt_q == LAST_WORD) && (row_cnt_q == LAST_ROW);

  odu_test_word_build #(
    .OH_BYTES   (OH_BYTES),
    .OH_PATTERN (OH_PATTERN)
  ) u_build (
    .seq_i      (seq_q),
    .rs_i       (is_rs),
    .inj_i      (inj_data_eff),
    .word_o     (bld_word),
    .seq_next_o (bld_seq)
  );

  // Next-state, counters and output-register inputs; a word is emitted on every RUN
  // cycle and on the IDLE cycle that sees i_enable.
  always_comb begin
    st_d          = st_q;
    word_cnt_d    = word_cnt_q;
    row_cnt_d     = row_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    seq_d         = seq_q;
    mfas_d        = mfas_q;
    seen_fs_d     = seen_fs_q;
    inj_data_d    = inj_data_eff;
    inj_mfas_d    = inj_mfas_eff;
    data_d        = data_q;
    valid_d       = 1'b0;
    fs_d          = fs_q;
    rs_d          = rs_q;
    mfas_out_d    = mfas_out_q;
    busy_d        = (word_cnt_q != '0) || (row_cnt_q != '0);
    frame_count_d = frame_count_q;
    emit          = 1'b0;

    case (st_q)
      ST_IDLE: emit = i_enable;
      ST_RUN:  emit = 1'b1;
      ST_GAP: begin
        if (gap_cnt_q <= 8'd1) st_d = ST_RUN;
        else                   gap_cnt_d = gap_cnt_q - 8'd1;
      end
      default: st_d = ST_IDLE;
    endcase

    if (emit) begin
      valid_d    = 1'b1;
      busy_d     = 1'b1;
      fs_d       = is_fs;
      rs_d       = is_rs;
      data_d     = bld_word;
      seq_d      = bld_seq;
      inj_data_d = 1'b0;

      // The internal MFAS only moves on fs words; injection touches the output copy only.
      if (is_fs) begin
        mfas_d     = seen_fs_q ? mfas_q + 8'd1 : mfas_q;
        seen_fs_d  = 1'b1;
        mfas_out_d = seen_fs_q ? mfas_q + 8'd1 : mfas_q;
      end else if (inj_mfas_eff) begin
        mfas_out_d = mfas_q + 8'd1;
        inj_mfas_d = 1'b0;
      end else begin
        mfas_out_d = mfas_q;
      end

      if (word_cnt_q == LAST_WORD) begin
        word_cnt_d = '0;
        row_cnt_d  = (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + 1'b1;
      end else begin
        word_cnt_d = word_cnt_q + 1'b1;
      end

      if (last_word) frame_count_d = frame_count_q + 16'd1;

      if (last_word && !i_enable) begin
        st_d = ST_IDLE;
      end else if (i_gap_len != 8'd0) begin
        st_d      = ST_GAP;
        gap_cnt_d = i_gap_len;
      end else begin
        st_d = ST_RUN;
      end
    end
  end

  // State and output registers; reset clears everything, including the data word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q          <= ST_IDLE;
      word_cnt_q    <= '0;
      row_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      seq_q         <= '0;
      mfas_q        <= '0;
      seen_fs_q     <= 1'b0;
      inj_data_q    <= 1'b0;
      inj_mfas_q    <= 1'b0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      fs_q          <= 1'b0;
      rs_q          <= 1'b0;
      mfas_out_q    <= '0;
      busy_q        <= 1'b0;
      frame_count_q <= '0;
    end else begin
      st_q          <= st_d;
      word_cnt_q    <= word_cnt_d;
      row_cnt_q     <= row_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      seq_q         <= seq_d;
      mfas_q        <= mfas_d;
      seen_fs_q     <= seen_fs_d;
      inj_data_q    <= inj_data_d;
      inj_mfas_q    <= inj_mfas_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      fs_q          <= fs_d;
      rs_q          <= rs_d;
      mfas_out_q    <= mfas_out_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign ch.data_chid   = data_q;
  assign ch.valid_chid  = valid_q;
  assign ch.fs_chid     = fs_q;
  assign ch.rs_chid     = rs_q;
  assign ch.mfas_chid   = mfas_out_q;
  assign o_busy         = busy_q;
  assign o_frame_count  = frame_count_q;
endmodule

// File: tb/tb_odu_test_gen.sv
// Scoreboard bench for odu_test_gen: a timing/content model predicts each word,
// a monitor compares every cycle and every valid word against it.
module tb_odu_test_gen;
  localparam int          WPR   = 4;
  localparam int          NROWS = 2;
  localparam int          OHB   = 2;
  localparam logic [15:0] OHP   = 16'hF628;

  typedef struct {
    int           edge_n;
    logic [383:0] data;
    logic         fs;
    logic         rs;
    logic [7:0]   mfas;
  } item_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        en    = 1'b0;
  logic [7:0]  gap   = 8'd0;
  logic        injd  = 1'b0;
  logic        injm  = 1'b0;
  logic        busy;
  logic [15:0] fc;

  odu_test_gen_if ch ();

  odu_test_gen #(
    .WORDS_PER_ROW (WPR),
    .ROWS          (NROWS),
    .OH_BYTES      (OHB),
    .OH_PATTERN    (OHP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_enable      (en),
    .i_gap_len     (gap),
    .i_inj_data    (injd),
    .i_inj_mfas    (injm),
    .ch            (ch.master),
    .o_busy        (busy),
    .o_frame_count (fc)
  );

  always #5 clk = ~clk;

  int pe = 0;
  always @(posedge clk) pe <= pe + 1;

  int n_cmp = 0;
  int n_bad = 0;

  item_t       q[$];
  bit          ev[int];
  bit          eb[int];
  logic [15:0] efc[int];

  // Model state: position in frame, sequence byte, MFAS and pending injections.
  int         m_next, m_widx, m_frames;
  bit         m_run, m_seen, m_pd, m_pm;
  logic [7:0] m_seq, m_mfas;

  task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_next = 0; m_widx = 0; m_frames = 0;
    m_run = 0; m_seen = 0; m_pd = 0; m_pm = 0;
    m_seq = 8'd0; m_mfas = 8'd0;
    q.delete();
    ev.delete(); eb.delete(); efc.delete();
  endtask

  // Predict what happens at clock edge e given the inputs now applied.
  task automatic model_step(input int e);
    item_t      it;
    bit         emit, pde, pme;
    int         first;
    logic [7:0] b;
    pde  = m_pd | injd;
    pme  = m_pm | injm;
    emit = (e >= m_next) && (m_run || en);
    if (emit) begin
      it.edge_n = e;
      it.rs     = (m_widx % WPR) == 0;
      it.fs     = (m_widx == 0);
      if (it.fs) begin
        if (m_seen) m_mfas = m_mfas + 8'd1;
        m_seen  = 1;
        it.mfas = m_mfas;
      end else if (pme) begin
        it.mfas = m_mfas + 8'd1;
        pme     = 0;
      end else begin
        it.mfas = m_mfas;
      end
      first   = it.rs ? OHB : 0;
      it.data = '0;
      for (int k = 0; k < 48; k++) begin
        if (k < first) begin
          b = ((k % 2) == 0) ? OHP[15:8] : OHP[7:0];
        end else begin
          b = m_seq + 8'(k - first);
          if (pde && k == first) b[0] = ~b[0];
        end
        it.data[383-8*k -: 8] = b;
      end
      pde    = 0;
      m_seq  = m_seq + 8'(48 - first);
      m_run  = 1;
      m_widx = m_widx + 1;
      if (m_widx == WPR * NROWS) begin
        m_widx   = 0;
        m_frames = m_frames + 1;
        m_run    = en;
        m_next   = en ? e + int'(gap) + 1 : e + 1;
      end else begin
        m_next = e + int'(gap) + 1;
      end
      q.push_back(it);
    end
    m_pd   = pde;
    m_pm   = pme;
    ev[e]  = emit;
    eb[e]  = emit || (m_widx != 0);
    efc[e] = 16'(m_frames);
  endtask

  task automatic cyc(input bit e, input int g, input bit d, input bit m);
    @(negedge clk);
    en   = e;
    gap  = 8'(g);
    injd = d;
    injm = m;
    model_step(pe + 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, 384'(ch.valid_chid), 384'(0));
    chk({tag, "_fs"},    384'(ch.fs_chid),    384'(0));
    chk({tag, "_rs"},    384'(ch.rs_chid),    384'(0));
    chk({tag, "_mfas"},  384'(ch.mfas_chid),  384'(0));
    chk({tag, "_data"},  ch.data_chid,        384'(0));
    chk({tag, "_busy"},  384'(busy),          384'(0));
    chk({tag, "_fc"},    384'(fc),            384'(0));
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0; injd = 1'b0; injm = 1'b0; gap = 8'd0;
    model_step(pe + 1);
  endtask

  // Monitor: per-cycle valid/busy/frame-count checks, and in-order word checks.
  initial begin : monitor
    item_t it;
    forever begin
      @(negedge clk);
      if (rst_n && ev.exists(pe)) begin
        chk("valid", 384'(ch.valid_chid), 384'(ev[pe]));
        chk("busy", 384'(busy), 384'(eb[pe]));
        chk("frame_count", 384'(fc), 384'(efc[pe]));
        if (ch.valid_chid) begin
          if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_word: got valid word at edge %0d, expected none", pe);
          end else begin
            it = q.pop_front();
            chk("word_edge", 384'(pe), 384'(it.edge_n));
            chk("data", ch.data_chid, it.data);
            chk("fs", 384'(ch.fs_chid), 384'(it.fs));
            chk("rs", 384'(ch.rs_chid), 384'(it.rs));
            chk("mfas", 384'(ch.mfas_chid), 384'(it.mfas));
          end
        end
      end
    end
  end

  initial begin : stim
    model_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    release_reset();

    // Back-to-back frames with enable held.
    repeat (30) cyc(1, 0, 0, 0);
    // Three-cycle gaps after every word.
    repeat (60) cyc(1, 3, 0, 0);
    // Enable dropped mid-frame: frame must complete, then idle.
    repeat (10) cyc(1, 0, 0, 0);
    repeat (25) cyc(0, 0, 0, 0);
    // Directed injections keyed to model frame position.
    for (int i = 0; i < 40; i++) begin
      cyc(1, 0, (m_widx == 3), (m_widx == 1));
    end
    // Random enable, gap and injection pulses.
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 9) != 0), int'($urandom_range(0, 3)),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end
    // Long continuous run so the MFAS wraps past 8'hFF.
    for (int i = 0; i < 2200; i++) begin
      cyc(1, 0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
    end
    // Asynchronous reset in the middle of a row.
    repeat (3) cyc(1, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    en = 1'b0; injd = 1'b0; injm = 1'b0;
    #1 check_zero_outputs("midreset");
    model_reset();
    repeat (3) @(negedge clk);
    release_reset();
    repeat (30) cyc(1, 0, 0, 0);
    repeat (20) cyc(0, 0, 0, 0);
    @(negedge clk);
    chk("queue_drained", 384'(q.size()), 384'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
